// File: rtl/fifo_nonlookahead_to_lookahead_pkg.sv
// rtl/fifo_nonlookahead_to_lookahead_pkg.sv - shared sizing for the non-lookahead to lookahead read adapter
// FIFO_N2L_DECOUPLE_EN selects the deeper buffer used by the registered-only issue rule.
package fifo_nonlookahead_to_lookahead_pkg;
`ifdef FIFO_N2L_DECOUPLE_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 2;
`endif
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/fifo_n2l_buf.sv
// rtl/fifo_n2l_buf.sv - DEPTH x DATA_WIDTH register queue holding words captured from upstream
// Plain storage with push/pop and head data; all protocol decisions live in the top level.
module fifo_n2l_buf
   import fifo_nonlookahead_to_lookahead_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output occ_t                  occ
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   ptr_t                  head;
   ptr_t                  tail;

   // Pointers are exactly PTR_W bits wide, so wrap modulo DEPTH falls out of the adder.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) begin
            mem[tail] <= din;
            tail      <= tail + ptr_t'(1);
         end
         if (pop) begin
            head <= head + ptr_t'(1);
         end
         occ <= occ + occ_t'(push) - occ_t'(pop);
      end
   end

   assign dout = mem[head];
endmodule

// File: rtl/fifo_nonlookahead_to_lookahead.sv
// rtl/fifo_nonlookahead_to_lookahead.sv - turns a non-lookahead FIFO read port into a lookahead one
// FIFO_N2L_DECOUPLE_EN: deeper buffer, _rd driven from registered state only.
module fifo_nonlookahead_to_lookahead
   import fifo_nonlookahead_to_lookahead_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  _empty,
   output logic                  _rd,
   input  logic [DATA_WIDTH-1:0] _dout,
   output logic                  empty,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] dout
);
   logic pending;
   logic pop;
   occ_t occ;

   assign empty = (occ == '0);
   assign pop   = rd && !empty;

`ifdef FIFO_N2L_DECOUPLE_EN
   // One slot of slack replaces the same-cycle pop credit, keeping rd off the _rd path.
   assign _rd = !rst && !_empty && ((occ + occ_t'(pending)) < occ_t'(DEPTH - 1));
`else
   assign _rd = !rst && !_empty && ((occ + occ_t'(pending) - occ_t'(pop)) < occ_t'(DEPTH));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else begin
         pending <= _rd && !_empty;
      end
   end

   fifo_n2l_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .push (pending),
      .pop  (pop),
      .din  (_dout),
      .dout (dout),
      .occ  (occ)
   );

   // The word in flight must always have a free slot waiting for it.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (occ + occ_t'(pending)) <= occ_t'(DEPTH));
endmodule
